// File: rtl/kt_solver_param.sv
`default_nettype none
// ============================================================================
// Module   : kt_solver_param
// Purpose  : Parametrised knight's-tour solver. Accepts a prefix path of a
//            knight on an N x N board, completes it with a depth-first search
//            in a programmable direction priority and streams the full path.
//            Unsolvable prefixes produce a single failure-report cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N             board side, 5..8
//   MW            step-count width, 2**MW > N*N
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      prefix strobe, one cell per cycle
//   in_x, in_y    prefix cell
//   move_num      prefix length (sampled on first in_valid cycle)
//   priority_num  first direction tried at every cell (sampled likewise)
//   out_valid     result strobe
//   out_x, out_y  path cell for move_out
//   move_out      1-based step index (0 on failure / idle)
//   out_fail      failure-report flag
// ============================================================================
module kt_solver_param #(
  parameter int N  = 5,
  parameter int MW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [2:0]    in_x,
  input  logic [2:0]    in_y,
  input  logic [MW-1:0] move_num,
  input  logic [2:0]    priority_num,
  output logic          out_valid,
  output logic [2:0]    out_x,
  output logic [2:0]    out_y,
  output logic [MW-1:0] move_out,
  output logic          out_fail
);

  localparam int            CELLS   = N * N;
  localparam int            IW      = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [MW-1:0] C_CELLS = MW'(CELLS);
  localparam logic [3:0]    C_N     = 4'(N);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INPUT = 3'd1,
    S_WALK  = 3'd2,
    S_OUT   = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_n;

  // Path stack, per-step direction stack and visited map
  logic [2:0]       r_px   [CELLS];
  logic [2:0]       r_py   [CELLS];
  logic [2:0]       r_dstk [CELLS];
  logic [CELLS-1:0] r_vis;

  logic [MW-1:0] r_depth;
  logic [MW-1:0] r_mnum;
  logic [2:0]    r_prio;
  logic [2:0]    r_dir;
  logic          r_exh;     // all 8 directions of the top cell tried

  logic          r_out_valid;
  logic          r_out_fail;
  logic [2:0]    r_out_x;
  logic [2:0]    r_out_y;
  logic [MW-1:0] r_move_out;

  function automatic logic [IW-1:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
    return IW'(int'(y) * N + int'(x));
  endfunction

  // --------------------------------------------------------------------------
  // Candidate evaluation from the top of the path stack
  // --------------------------------------------------------------------------
  logic [IW-1:0] w_top;
  logic [IW-1:0] w_par;
  logic [IW-1:0] w_wr;
  logic [2:0]    w_tx;
  logic [2:0]    w_ty;
  logic [3:0]    w_dx;
  logic [3:0]    w_dy;
  logic [3:0]    w_cx;
  logic [3:0]    w_cy;
  logic [IW-1:0] w_cidx;
  logic          w_cand_ok;
  logic          w_full;
  logic          w_last_push;
  logic          w_pop_fail;
  logic [2:0]    w_dir_nx;
  logic [2:0]    w_par_nx;

  assign w_top = IW'(r_depth - MW'(1));
  assign w_par = IW'(r_depth - MW'(2));
  assign w_wr  = IW'(r_depth);
  assign w_tx  = r_px[w_top];
  assign w_ty  = r_py[w_top];

  always_comb begin
    w_dx = 4'h0;
    w_dy = 4'h0;
    case (r_dir)
      3'd0:    begin w_dx = 4'hF; w_dy = 4'h2; end
      3'd1:    begin w_dx = 4'h1; w_dy = 4'h2; end
      3'd2:    begin w_dx = 4'h2; w_dy = 4'h1; end
      3'd3:    begin w_dx = 4'h2; w_dy = 4'hF; end
      3'd4:    begin w_dx = 4'h1; w_dy = 4'hE; end
      3'd5:    begin w_dx = 4'hF; w_dy = 4'hE; end
      3'd6:    begin w_dx = 4'hE; w_dy = 4'hF; end
      default: begin w_dx = 4'hE; w_dy = 4'h1; end
    endcase
  end

  // Signed 4-bit arithmetic: bit 3 set means negative or >= 8, both off-board
  assign w_cx      = {1'b0, w_tx} + w_dx;
  assign w_cy      = {1'b0, w_ty} + w_dy;
  assign w_cidx    = cell_idx(w_cx[2:0], w_cy[2:0]);
  assign w_cand_ok = !w_cx[3] && (w_cx < C_N) && !w_cy[3] && (w_cy < C_N) && !r_vis[w_cidx];

  assign w_full      = (r_depth == C_CELLS);
  assign w_last_push = ((r_depth + MW'(1)) == C_CELLS);
  assign w_pop_fail  = (r_depth <= r_mnum);   // prefix cells are never popped
  assign w_dir_nx    = r_dir + 3'd1;
  assign w_par_nx    = r_dstk[w_par] + 3'd1;

  logic w_start;
  logic w_append;
  logic w_walk;
  logic w_accept;
  logic w_pop;

  assign w_start  = (r_state == S_IDLE) && in_valid;
  assign w_append = (r_state == S_INPUT) && in_valid && !w_full;
  assign w_walk   = (r_state == S_WALK) && !w_full;
  assign w_accept = w_walk && !r_exh && w_cand_ok;
  assign w_pop    = w_walk && r_exh && !w_pop_fail;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_n = S_INPUT;
      S_INPUT: if (!in_valid) w_state_n = S_WALK;
      S_WALK: begin
        if (w_full)                       w_state_n = S_OUT;
        else if (r_exh && w_pop_fail)     w_state_n = S_FAIL;
        else if (w_accept && w_last_push) w_state_n = S_OUT;
      end
      S_OUT:   if (r_move_out == C_CELLS) w_state_n = S_IDLE;
      S_FAIL:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Path and direction stacks (contents only meaningful below r_depth)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_px[0] <= in_x;
      r_py[0] <= in_y;
    end else if (w_append) begin
      r_px[w_wr] <= in_x;
      r_py[w_wr] <= in_y;
    end else if (w_accept) begin
      r_px[w_wr]    <= w_cx[2:0];
      r_py[w_wr]    <= w_cy[2:0];
      r_dstk[w_top] <= r_dir;
    end
  end

  // --------------------------------------------------------------------------
  // Search control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vis   <= '0;
      r_depth <= '0;
      r_mnum  <= '0;
      r_prio  <= '0;
      r_dir   <= '0;
      r_exh   <= 1'b0;
    end else begin
      if (w_start) begin
        r_vis                    <= '0;
        r_vis[cell_idx(in_x, in_y)] <= 1'b1;
        r_depth                  <= MW'(1);
        r_mnum                   <= move_num;
        r_prio                   <= priority_num;
      end else if (w_append) begin
        r_vis[cell_idx(in_x, in_y)] <= 1'b1;
        r_depth                  <= r_depth + MW'(1);
      end else if ((r_state == S_INPUT) && !in_valid) begin
        r_dir <= r_prio;
        r_exh <= 1'b0;
      end else if (w_pop) begin
        r_vis[cell_idx(w_tx, w_ty)] <= 1'b0;
        r_depth                  <= r_depth - MW'(1);
        // Parent resumes at its stored direction + 1 unless that wraps too
        if (w_par_nx == r_prio) begin
          r_exh <= 1'b1;
        end else begin
          r_dir <= w_par_nx;
          r_exh <= 1'b0;
        end
      end else if (w_accept) begin
        r_vis[w_cidx] <= 1'b1;
        r_depth       <= r_depth + MW'(1);
        r_dir         <= r_prio;
      end else if (w_walk && !r_exh) begin
        if (w_dir_nx == r_prio) r_exh <= 1'b1;
        else                    r_dir <= w_dir_nx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs, loaded from the next state so they align with it
  // --------------------------------------------------------------------------
  logic [IW-1:0] w_oidx;
  logic [MW-1:0] w_omove;

  assign w_oidx  = (r_state == S_OUT) ? IW'(r_move_out) : '0;
  assign w_omove = (r_state == S_OUT) ? (r_move_out + MW'(1)) : MW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_fail  <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_move_out  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_fail  <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_move_out  <= '0;
      if (w_state_n == S_OUT) begin
        r_out_valid <= 1'b1;
        r_out_x     <= r_px[w_oidx];
        r_out_y     <= r_py[w_oidx];
        r_move_out  <= w_omove;
      end else if (w_state_n == S_FAIL) begin
        r_out_valid <= 1'b1;
        r_out_fail  <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_fail  = r_out_fail;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign move_out  = r_move_out;

endmodule
`default_nettype wire

// File: tb/tb_kt_solver_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_kt_solver_param
// Purpose  : Scoreboard bench for kt_solver_param (N=5). A plain DFS model
//            predicts every output cycle and the search latency; a monitor
//            compares whatever the DUT presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kt_solver_param;

  localparam int N           = 5;
  localparam int MW          = 5;
  localparam int C           = N * N;
  localparam int MAXW        = 15000;
  localparam int WALK_BUDGET = 60000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [2:0]    in_x, in_y, priority_num;
  logic [MW-1:0] move_num;
  logic          out_valid, out_fail;
  logic [2:0]    out_x, out_y;
  logic [MW-1:0] move_out;

  kt_solver_param #(.N(N), .MW(MW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .move_num(move_num), .priority_num(priority_num), .out_valid(out_valid),
    .out_x(out_x), .out_y(out_y), .move_out(move_out), .out_fail(out_fail)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic          fail;
    logic [2:0]    x;
    logic [2:0]    y;
    logic [MW-1:0] mv;
  } exp_t;

  exp_t  q_exp[$];
  int    q_lat[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  bit    prev_ov = 1'b0;
  int    walk_used = 0;
  string cur_name = "reset";

  int DXT[8] = '{-1, 1, 2, 2, 1, -1, -2, -2};
  int DYT[8] = '{ 2, 2, 1, -1, -2, -2, -1, 1};

  int pfx_x[64], pfx_y[64], pfx_n;
  int m_px[64], m_py[64];
  int tour_x[64], tour_y[64];
  bit have_tour = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // --------------------------------------------------------------------------
  // Monitor: compares every presented output against the scoreboard
  // --------------------------------------------------------------------------
  initial forever begin
    @(negedge clk);
    if (mon_en && rst_n) begin
      if (out_valid) begin
        if (!prev_ov) begin
          checks++;
          if (q_lat.size() == 0) begin
            errors++;
            $display("FAIL %s latency: out_valid rose at cycle %0d, expected no output", cur_name, cyc);
          end else begin
            int l;
            l = q_lat.pop_front();
            if (cyc != l) begin
              errors++;
              $display("FAIL %s latency: out_valid rose at cycle %0d, expected cycle %0d", cur_name, cyc, l);
            end
          end
        end
        checks++;
        if (q_exp.size() == 0) begin
          errors++;
          $display("FAIL %s extra output: fail=%0b x=%0d y=%0d move=%0d, expected out_valid low",
                   cur_name, out_fail, out_x, out_y, move_out);
        end else begin
          exp_t e;
          e = q_exp.pop_front();
          if ({out_fail, out_x, out_y, move_out} != e) begin
            errors++;
            $display("FAIL %s output: got fail=%0b x=%0d y=%0d move=%0d, expected fail=%0b x=%0d y=%0d move=%0d",
                     cur_name, out_fail, out_x, out_y, move_out, e.fail, e.x, e.y, e.mv);
          end
        end
      end else begin
        checks++;
        if ({out_fail, out_x, out_y, move_out} != '0) begin
          errors++;
          $display("FAIL %s idle outputs: got fail=%0b x=%0d y=%0d move=%0d, expected all 0",
                   cur_name, out_fail, out_x, out_y, move_out);
        end
      end
    end
    prev_ov = rst_n ? out_valid : 1'b0;
  end

  // --------------------------------------------------------------------------
  // Reference model: DFS where each cell counts how many directions it has
  // tried; one cycle per candidate, one per pop (including the failing one)
  // --------------------------------------------------------------------------
  task automatic run_model(input int prio, output int status, output int w);
    bit vis[8][8];
    int px[64], py[64], tried[64];
    int d, t, dir, nx, ny;
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) vis[i][j] = 1'b0;
    for (int i = 0; i < pfx_n; i++) begin
      px[i] = pfx_x[i]; py[i] = pfx_y[i]; vis[px[i]][py[i]] = 1'b1;
    end
    d = pfx_n;
    tried[d-1] = 0;
    w = 0;
    status = 2;
    if (d == C) begin
      w = 1;
      status = 0;
    end else begin
      while (w < MAXW) begin
        t = d - 1;
        w++;
        if (tried[t] == 8) begin
          if (d <= pfx_n) begin status = 1; break; end
          vis[px[t]][py[t]] = 1'b0;
          d--;
          tried[d-1]++;
        end else begin
          dir = (prio + tried[t]) % 8;
          nx = px[t] + DXT[dir];
          ny = py[t] + DYT[dir];
          if (nx >= 0 && nx < N && ny >= 0 && ny < N && !vis[nx][ny]) begin
            px[d] = nx; py[d] = ny; vis[nx][ny] = 1'b1;
            d++;
            tried[d-1] = 0;
            if (d == C) begin status = 0; break; end
          end else begin
            tried[t]++;
          end
        end
      end
    end
    for (int i = 0; i < C; i++) begin m_px[i] = px[i]; m_py[i] = py[i]; end
  endtask

  // Random knight walk of up to len distinct cells from (sx,sy)
  task automatic gen_prefix(input int sx, input int sy, input int len);
    bit vis[8][8];
    int cx[8], cy[8], nc, k, nx, ny;
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) vis[i][j] = 1'b0;
    pfx_x[0] = sx; pfx_y[0] = sy; pfx_n = 1; vis[sx][sy] = 1'b1;
    while (pfx_n < len) begin
      nc = 0;
      for (int d = 0; d < 8; d++) begin
        nx = pfx_x[pfx_n-1] + DXT[d];
        ny = pfx_y[pfx_n-1] + DYT[d];
        if (nx >= 0 && nx < N && ny >= 0 && ny < N && !vis[nx][ny]) begin
          cx[nc] = nx; cy[nc] = ny; nc++;
        end
      end
      if (nc == 0) break;
      k = $urandom_range(0, nc - 1);
      pfx_x[pfx_n] = cx[k]; pfx_y[pfx_n] = cy[k]; vis[cx[k]][cy[k]] = 1'b1;
      pfx_n++;
    end
  endtask

  // Drives the prefix; move_num/priority carry junk after the first cycle
  task automatic drive_prefix(input int prio, output int fall_cyc);
    for (int i = 0; i < pfx_n; i++) begin
      @(negedge clk);
      in_valid     = 1'b1;
      in_x         = 3'(pfx_x[i]);
      in_y         = 3'(pfx_y[i]);
      move_num     = (i == 0) ? MW'(pfx_n) : MW'($urandom);
      priority_num = (i == 0) ? 3'(prio) : 3'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0; in_x = '0; in_y = '0; move_num = '0; priority_num = '0;
    fall_cyc = cyc;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    q_exp.delete();
    q_lat.delete();
    rst_n = 1'b1;
  endtask

  task automatic checked_run(input int prio);
    int status, w, fall, lim, k;
    run_model(prio, status, w);
    if (status == 2 || walk_used + w > WALK_BUDGET) begin
      $display("note: %s skipped, search exceeds bench cycle budget", cur_name);
      return;
    end
    walk_used += w;
    if (status == 0) begin
      for (int i = 0; i < C; i++) begin
        q_exp.push_back({1'b0, 3'(m_px[i]), 3'(m_py[i]), MW'(i + 1)});
        tour_x[i] = m_px[i]; tour_y[i] = m_py[i];
      end
      have_tour = 1'b1;
    end else begin
      q_exp.push_back({1'b1, 3'd0, 3'd0, MW'(0)});
    end
    drive_prefix(prio, fall);
    q_lat.push_back(fall + 1 + w);
    lim = w + C + 40;
    k = 0;
    while ((q_exp.size() != 0 || q_lat.size() != 0 || out_valid) && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (k >= lim) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d outputs still pending after %0d cycles, expected 0",
               cur_name, q_exp.size(), k);
      pulse_reset();
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string what);
    checks++;
    if ({out_valid, out_fail, out_x, out_y, move_out} != '0) begin
      errors++;
      $display("FAIL %s: got valid=%0b fail=%0b x=%0d y=%0d move=%0d, expected all 0",
               what, out_valid, out_fail, out_x, out_y, move_out);
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int fall, k, st, w;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; move_num = '0; priority_num = '0;
    repeat (3) @(negedge clk);
    check_zero("reset state");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("after reset release");
    mon_en = 1'b1;

    cur_name = "corner_p0";
    pfx_x[0] = 0; pfx_y[0] = 0; pfx_n = 1;
    checked_run(0);

    cur_name = "prefix3_p5";
    pfx_x[0] = 0; pfx_y[0] = 0; pfx_x[1] = 1; pfx_y[1] = 2; pfx_x[2] = 2; pfx_y[2] = 4; pfx_n = 3;
    checked_run(5);

    cur_name = "odd_start";
    pfx_x[0] = 0; pfx_y[0] = 1; pfx_n = 1;
    checked_run($urandom_range(0, 7));

    cur_name = "odd_prefix";
    gen_prefix(0, 1, 10);
    checked_run($urandom_range(0, 7));

    for (int r = 0; r < 12; r++) begin
      $sformat(cur_name, "random%0d", r);
      gen_prefix($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(9, 20));
      checked_run($urandom_range(0, 7));
    end

    for (int a = 0; a < 100 && !have_tour; a++) begin
      gen_prefix(0, 0, 15);
      run_model(0, st, w);
      if (st == 0) begin
        for (int i = 0; i < C; i++) begin tour_x[i] = m_px[i]; tour_y[i] = m_py[i]; end
        have_tour = 1'b1;
      end
    end

    if (have_tour) begin
      cur_name = "full_echo";
      for (int i = 0; i < C; i++) begin pfx_x[i] = tour_x[i]; pfx_y[i] = tour_y[i]; end
      pfx_n = C;
      checked_run($urandom_range(0, 7));

      // Reset in the middle of the output stream
      cur_name = "abort_out";
      mon_en = 1'b0;
      drive_prefix(0, fall);
      k = 0;
      while (!out_valid && k < 20) begin @(negedge clk); k++; end
      checks++;
      if (!out_valid) begin
        errors++;
        $display("FAIL abort_out: out_valid=%0b before reset, expected 1", out_valid);
      end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("abort_out async clear");
      pulse_reset();
      mon_en = 1'b1;
    end

    // Reset in the middle of a search
    cur_name = "abort_walk";
    mon_en = 1'b0;
    gen_prefix(0, 0, 4);
    drive_prefix(0, fall);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("abort_walk async clear");
    pulse_reset();
    mon_en = 1'b1;

    cur_name = "center_p3";
    pfx_x[0] = 2; pfx_y[0] = 2; pfx_n = 1;
    checked_run(3);
    cur_name = "center_ext_p3";
    gen_prefix(2, 2, 13);
    checked_run(3);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
